// File: rtl/mem_readback_scanner.sv
// -----------------------------------------------------------------------------
// mem_readback_scanner
//
// Sweeps every address of a block RAM's registered read port, streams each word
// out over a valid/ready interface and checks it against the even/odd tile
// pattern, so a reinitialised RAM can be shown to hold its original contents.
//
// Ports
//   clk              sole clock, rising edge
//   reset            synchronous, active-high reset
//   start            begin a scan (honoured only in IDLE or DONE)
//   cmp_en           count mismatches for this scan (sampled with start)
//   raddr            memory read address (holds when no read is issued)
//   rdata            memory read data, valid the cycle after raddr
//   m_valid/m_ready  stream handshake
//   m_data/m_addr    streamed word and its address
//   m_last           high with the word at address DEPTH-1
//   busy             high while scanning or draining
//   done             level, high from scan completion until next start/reset
//   err_count        mismatch count for the current or last scan
//   first_err_valid  at least one mismatch seen
//   first_err_addr   address of the first mismatch
// -----------------------------------------------------------------------------
module mem_readback_scanner #(
    parameter int              ADDR_W   = 12,
    parameter int              DEPTH    = 4096,
    parameter int              WID      = 18,
    parameter logic [WID-1:0]  PAT_EVEN = 18'h0AA55,
    parameter logic [WID-1:0]  PAT_ODD  = 18'h355AA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cmp_en,
    output logic [ADDR_W-1:0] raddr,
    input  logic [WID-1:0]    rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WID-1:0]    m_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   err_count,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [WID-1:0]    data;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } entry_t;

    state_t            state_q, state_d;

    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;   // next address to issue
    logic [ADDR_W-1:0] raddr_q, raddr_d;         // last issued address
    logic              cap_q, cap_d;             // rdata holds a real read this cycle
    logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;   // address of that read
    logic              cmp_en_q, cmp_en_d;
    logic [ADDR_W:0]   err_count_q, err_count_d;
    logic              first_err_valid_q, first_err_valid_d;
    logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;

    // Two-entry output buffer; ent0 is the head and drives m_* directly.
    entry_t            ent0_q, ent0_d;
    entry_t            ent1_q, ent1_d;
    logic [1:0]        count_q, count_d;

    logic              start_ok;
    logic              pop;
    logic              issue;
    logic              mismatch;
    logic [WID-1:0]    expected;
    entry_t            new_ent;

    // ------------------------------------------------------------------
    // Handshake and read-issue decisions
    // ------------------------------------------------------------------
    assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
    assign pop      = (count_q != 2'd0) && m_ready;

    // Issue only while the words already held plus the one in flight, less
    // the one leaving now, leave room for another: the buffer can never
    // overflow, and with m_ready high the pipe still sustains one word/cycle.
    assign issue = (state_q == S_SCAN) &&
                   (({1'b0, count_q} + {2'b00, cap_q} - {2'b00, pop}) < 3'd2);

    assign raddr = issue ? addr_cnt_q : raddr_q;

    assign expected = cap_addr_q[0] ? PAT_ODD : PAT_EVEN;
    assign mismatch = cap_q && cmp_en_q && (rdata != expected);

    assign new_ent = '{data: rdata, addr: cap_addr_q, last: (cap_addr_q == LAST_ADDR)};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: flops use non-blocking assignments so every register samples the
    // pre-edge values of the others, independent of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start)                          state_d = S_SCAN;
            S_SCAN:  if (issue && addr_cnt_q == LAST_ADDR) state_d = S_DRAIN;
            S_DRAIN: if (pop && ent0_q.last)             state_d = S_DONE;
            S_DONE:  if (start)                          state_d = S_SCAN;
            default:                                     state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q == S_SCAN) || (state_q == S_DRAIN);
        done = (state_q == S_DONE);
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        addr_cnt_d        = addr_cnt_q;
        raddr_d           = raddr_q;
        cap_d             = issue;
        cap_addr_d        = cap_addr_q;
        cmp_en_d          = cmp_en_q;
        err_count_d       = err_count_q;
        first_err_valid_d = first_err_valid_q;
        first_err_addr_d  = first_err_addr_q;
        ent0_d            = ent0_q;
        ent1_d            = ent1_q;
        count_d           = count_q;

        if (start_ok) begin
            addr_cnt_d        = '0;
            cmp_en_d          = cmp_en;
            err_count_d       = '0;
            first_err_valid_d = 1'b0;
            first_err_addr_d  = '0;
        end

        if (issue) begin
            addr_cnt_d = addr_cnt_q + 1'b1;
            raddr_d    = addr_cnt_q;
            cap_addr_d = addr_cnt_q;
        end

        // Compare on capture; nothing is in flight in IDLE/DONE, so this never
        // collides with the clear done by start.
        if (mismatch) begin
            err_count_d = err_count_q + 1'b1;
            if (!first_err_valid_q) begin
                first_err_valid_d = 1'b1;
                first_err_addr_d  = cap_addr_q;
            end
        end

        unique case ({cap_q, pop})
            2'b01: begin
                ent0_d  = ent1_q;
                count_d = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) ent0_d = new_ent;
                else                 ent1_d = new_ent;
                count_d = count_q + 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    ent0_d = new_ent;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = new_ent;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: the buffer entries are reset even though they are storage, because
    // the head entry drives m_data/m_addr/m_last straight to the ports and
    // those must read zero out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_cnt_q        <= '0;
            raddr_q           <= '0;
            cap_q             <= 1'b0;
            cap_addr_q        <= '0;
            cmp_en_q          <= 1'b0;
            err_count_q       <= '0;
            first_err_valid_q <= 1'b0;
            first_err_addr_q  <= '0;
            ent0_q            <= '0;
            ent1_q            <= '0;
            count_q           <= 2'd0;
        end else begin
            addr_cnt_q        <= addr_cnt_d;
            raddr_q           <= raddr_d;
            cap_q             <= cap_d;
            cap_addr_q        <= cap_addr_d;
            cmp_en_q          <= cmp_en_d;
            err_count_q       <= err_count_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_addr_q  <= first_err_addr_d;
            ent0_q            <= ent0_d;
            ent1_q            <= ent1_d;
            count_q           <= count_d;
        end
    end

    assign m_valid         = (count_q != 2'd0);
    assign m_data          = ent0_q.data;
    assign m_addr          = ent0_q.addr;
    assign m_last          = ent0_q.last;
    assign err_count       = err_count_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_addr  = first_err_addr_q;

endmodule

// File: tb/tb_mem_readback_scanner.sv
// -----------------------------------------------------------------------------
// tb_mem_readback_scanner
//
// Self-checking bench: a behavioural registered-read RAM, a table of scan
// scenarios with their expected results, a random-corruption scan whose
// expectations come from a whole-array model, and hand-written sequences for
// mid-scan reset and the stalled-start corner.
// -----------------------------------------------------------------------------
module tb_mem_readback_scanner;

    localparam int             ADDR_W   = 12;
    localparam int             DEPTH    = 4096;
    localparam int             WID      = 18;
    localparam logic [WID-1:0] PAT_EVEN = 18'h0AA55;
    localparam logic [WID-1:0] PAT_ODD  = 18'h355AA;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              cmp_en;
    logic [ADDR_W-1:0] raddr;
    logic [WID-1:0]    rdata;
    logic              m_valid;
    logic              m_ready;
    logic [WID-1:0]    m_data;
    logic [ADDR_W-1:0] m_addr;
    logic              m_last;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   err_count;
    logic              first_err_valid;
    logic [ADDR_W-1:0] first_err_addr;

    mem_readback_scanner #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .WID     (WID),
        .PAT_EVEN(PAT_EVEN),
        .PAT_ODD (PAT_ODD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cmp_en         (cmp_en),
        .raddr          (raddr),
        .rdata          (rdata),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_addr         (m_addr),
        .m_last         (m_last),
        .busy           (busy),
        .done           (done),
        .err_count      (err_count),
        .first_err_valid(first_err_valid),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    // Behavioural RAM with a registered read port.
    logic [WID-1:0] mem [DEPTH];
    always @(posedge clk) rdata <= mem[raddr];

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Stream monitor (samples on the falling edge)
    // ------------------------------------------------------------------
    bit             mon_en    = 1'b0;
    bit             mon_clear = 1'b0;
    int             acc, stream_bad, stall_bad, ahead_bad, last_cnt;
    logic           prev_stall;
    logic [WID-1:0] sd, d123;
    logic [ADDR_W-1:0] sa;
    logic           sl;

    always @(negedge clk) begin
        if (mon_clear) begin
            acc        <= 0;
            stream_bad <= 0;
            stall_bad  <= 0;
            ahead_bad  <= 0;
            last_cnt   <= 0;
            prev_stall <= 1'b0;
            d123       <= '1;
        end else if (mon_en) begin
            if (prev_stall && !(m_valid && m_data == sd && m_addr == sa && m_last == sl))
                stall_bad <= stall_bad + 1;
            prev_stall <= m_valid && !m_ready;
            sd <= m_data;
            sa <= m_addr;
            sl <= m_last;
            if (m_valid && m_ready) begin
                if (acc >= DEPTH || int'(m_addr) != acc || m_data != mem[acc % DEPTH] ||
                    m_last != (acc == DEPTH - 1))
                    stream_bad <= stream_bad + 1;
                if (m_last) last_cnt <= last_cnt + 1;
                if (m_addr == 12'h123) d123 <= m_data;
                acc <= acc + 1;
            end
            // Last accepted address (this cycle included) is acc-1 or acc.
            if (int'(raddr) > acc + ((m_valid && m_ready) ? 1 : 0) + 1)
                ahead_bad <= ahead_bad + 1;
        end
    end

    // ------------------------------------------------------------------
    // Memory setup and reference model
    // ------------------------------------------------------------------
    task automatic fill_tile();
        for (int k = 0; k < DEPTH; k++) mem[k] = (k % 2 == 1) ? PAT_ODD : PAT_EVEN;
    endtask

    task automatic apply_tile_errors();
        mem[12'h123] = 18'h00000;
        mem[12'hFFF] = 18'h0AA55;
    endtask

    task automatic model(input bit cmp, output int errs, output bit fv, output int fa);
        errs = 0;
        fv   = 1'b0;
        fa   = 0;
        if (cmp) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (mem[k] != ((k % 2 == 1) ? PAT_ODD : PAT_EVEN)) begin
                    if (!fv) fa = k;
                    fv = 1'b1;
                    errs++;
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Scan driver
    // ------------------------------------------------------------------
    int                lat;
    bit                aborted;
    logic              busy1, done1, fv1;
    logic [ADDR_W:0]   err1;
    logic [ADDR_W-1:0] stall_ma, stall_ra;
    logic              stall_mv;

    // mode 0: m_ready high, 1: random 50%, 2: low for 10 cycles from first m_valid
    task automatic run_scan(input bit cmp, input int mode, input bit glitch, input int abort_at);
        int stall_left = 0;
        bit st_started = 1'b0;
        bit st_rec     = 1'b0;
        lat     = -1;
        aborted = 1'b0;
        mon_en    = 1'b0;
        mon_clear = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 20000; n++) begin
            @(posedge clk);
            #1;
            if (aborted) begin
                reset  = 1'b0;
                mon_en = 1'b0;
                break;
            end
            if (mode == 2 && st_started && stall_left == 0 && !st_rec) begin
                st_rec   = 1'b1;
                stall_ma = m_addr;
                stall_ra = raddr;
                stall_mv = m_valid;
            end
            if (n == 1) begin
                busy1  = busy;
                done1  = done;
                err1   = err_count;
                fv1    = first_err_valid;
                mon_en = 1'b1;
            end
            if (n >= 1 && done) begin
                lat = n;
                break;
            end
            mon_clear = 1'b0;
            start  = (n == 0) || (glitch && n == 100);
            cmp_en = (n == 0) ? cmp : ~cmp;
            case (mode)
                1: m_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (!st_started && m_valid) begin
                        st_started = 1'b1;
                        stall_left = 10;
                    end
                    if (stall_left > 0) begin
                        m_ready = 1'b0;
                        stall_left--;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
                default: m_ready = 1'b1;
            endcase
            if (abort_at >= 0 && m_valid && int'(m_addr) == abort_at) begin
                reset   = 1'b1;
                aborted = 1'b1;
            end
        end
        start   = 1'b0;
        m_ready = 1'b1;
        mon_en  = 1'b0;
    endtask

    task automatic check_scan(input string tag, input int exp_err, input bit exp_fv,
                              input int exp_fa, input int exp_lat);
        if (exp_lat >= 0) check({tag, " done cycle"}, lat, exp_lat);
        else              check({tag, " done reached"}, 32'(lat > 0), 1);
        check({tag, " err_count"},       32'(err_count), exp_err);
        check({tag, " first_err_valid"}, 32'(first_err_valid), 32'(exp_fv));
        check({tag, " first_err_addr"},  32'(first_err_addr), exp_fa);
        check({tag, " busy at done"},    32'(busy), 0);
        check({tag, " words accepted"},  acc, DEPTH);
        check({tag, " stream errors"},   stream_bad, 0);
        check({tag, " stall changes"},   stall_bad, 0);
        check({tag, " raddr run-ahead"}, ahead_bad, 0);
        check({tag, " m_last count"},    last_cnt, 1);
        check({tag, " busy cycle 1"},    32'(busy1), 1);
        check({tag, " done cycle 1"},    32'(done1), 0);
        check({tag, " err cleared"},     32'(err1), 0);
        check({tag, " first_err cleared"}, 32'(fv1), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " raddr"},           32'(raddr), 0);
        check({tag, " m_valid"},         32'(m_valid), 0);
        check({tag, " m_data"},          32'(m_data), 0);
        check({tag, " m_addr"},          32'(m_addr), 0);
        check({tag, " m_last"},          32'(m_last), 0);
        check({tag, " busy"},            32'(busy), 0);
        check({tag, " done"},            32'(done), 0);
        check({tag, " err_count"},       32'(err_count), 0);
        check({tag, " first_err_valid"}, 32'(first_err_valid), 0);
        check({tag, " first_err_addr"},  32'(first_err_addr), 0);
    endtask

    // ------------------------------------------------------------------
    // Scenario table
    // ------------------------------------------------------------------
    typedef struct {
        string name;
        bit    tile_err;
        bit    cmp;
        int    mode;
        bit    glitch;
        int    exp_err;
        bit    exp_fv;
        int    exp_fa;
        int    exp_lat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m_err;
        bit m_fv;
        int m_fa;
        int a;

        vecs[0] = '{name:"clean",      tile_err:0, cmp:1, mode:0, glitch:0, exp_err:0, exp_fv:0, exp_fa:0,     exp_lat:4099};
        vecs[1] = '{name:"tile_err",   tile_err:1, cmp:1, mode:0, glitch:0, exp_err:2, exp_fv:1, exp_fa:'h123, exp_lat:4099};
        vecs[2] = '{name:"cmp_off",    tile_err:1, cmp:0, mode:0, glitch:0, exp_err:0, exp_fv:0, exp_fa:0,     exp_lat:4099};
        vecs[3] = '{name:"rescan_err", tile_err:1, cmp:1, mode:0, glitch:0, exp_err:2, exp_fv:1, exp_fa:'h123, exp_lat:4099};
        vecs[4] = '{name:"rand_ready", tile_err:0, cmp:1, mode:1, glitch:0, exp_err:0, exp_fv:0, exp_fa:0,     exp_lat:-1};
        vecs[5] = '{name:"stall10",    tile_err:0, cmp:1, mode:2, glitch:0, exp_err:0, exp_fv:0, exp_fa:0,     exp_lat:4109};
        vecs[6] = '{name:"start_glitch", tile_err:0, cmp:1, mode:0, glitch:1, exp_err:0, exp_fv:0, exp_fa:0,   exp_lat:4099};

        reset   = 1'b1;
        start   = 1'b0;
        cmp_en  = 1'b0;
        m_ready = 1'b1;
        fill_tile();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        foreach (vecs[i]) begin
            fill_tile();
            if (vecs[i].tile_err) apply_tile_errors();
            run_scan(vecs[i].cmp, vecs[i].mode, vecs[i].glitch, -1);
            check_scan(vecs[i].name, vecs[i].exp_err, vecs[i].exp_fv, vecs[i].exp_fa, vecs[i].exp_lat);
            if (vecs[i].tile_err) check({vecs[i].name, " m_data at 0x123"}, 32'(d123), 0);
            if (vecs[i].mode == 2) begin
                check("stall m_addr held",   32'(stall_ma), 0);
                check("stall raddr reads",   32'(stall_ra), 1);
                check("stall m_valid held",  32'(stall_mv), 1);
            end
        end

        // Reset one cycle at word 2000 of an erroring scan, then a clean rescan.
        fill_tile();
        apply_tile_errors();
        run_scan(1'b1, 0, 1'b0, 2000);
        check("mid-scan reset reached", 32'(aborted), 1);
        check_reset_outputs("mid-scan reset");
        check("pre-reset stream errors", stream_bad, 0);
        fill_tile();
        run_scan(1'b1, 0, 1'b0, -1);
        check_scan("post_reset", 0, 1'b0, 0, 4099);

        // Random corruptions with random backpressure, judged by the model.
        fill_tile();
        for (int j = 0; j < 8; j++) begin
            a = $urandom_range(0, DEPTH - 1);
            mem[a] = WID'($urandom);
        end
        model(1'b1, m_err, m_fv, m_fa);
        run_scan(1'b1, 1, 1'b0, -1);
        check_scan("rand_corrupt", m_err, m_fv, m_fa, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
